// File: rtl/ioctl_loader.sv
// Download loader: routes ioctl byte stream into ROM/RAM regions or a config
// register, holds the emulated core in reset while loading and settling.
module ioctl_loader #(
    parameter int         ADDR_W        = 16,
    parameter int         NUM_REGIONS   = 4,
    parameter logic [7:0] CFG_INDEX     = 8'd1,
    parameter int         CFG_BYTES     = 4,
    parameter int         SETTLE_CYCLES = 16
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     ioctl_download,
    input  logic [7:0]               ioctl_index,
    input  logic                     ioctl_wr,
    input  logic [24:0]              ioctl_addr,
    input  logic [7:0]               ioctl_dout,
    output logic [ADDR_W-1:0]        dn_addr,
    output logic [7:0]               dn_data,
    output logic [NUM_REGIONS-1:0]   dn_wr,
    output logic [CFG_BYTES*8-1:0]   cfg,
    output logic                     core_reset,
    output logic                     done,
    output logic [7:0]               checksum,
    output logic [24:0]              byte_count,
    output logic                     err
);

    localparam int                CNT_W       = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [25:0]       ADDR_LIMIT  = 26'd1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, LOAD, SETTLE} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        settle_cnt;
    logic                    accept;
    logic                    start;
    logic                    settle_load;
    logic                    settle_end;
    logic                    is_cfg;
    logic                    cfg_hit;
    logic                    mem_hit;
    logic [NUM_REGIONS-1:0]  region_onehot;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The settle hold ends on the edge where the counter steps down to zero,
    // so core_reset is released SETTLE_CYCLES edges after the download drops.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        start       = 1'b0;
        settle_load = 1'b0;
        settle_end  = 1'b0;
        case (state)
            IDLE: begin
                if (ioctl_download) begin
                    state_next = LOAD;
                    start      = 1'b1;
                end
            end
            LOAD: begin
                accept = ioctl_wr;
                if (!ioctl_download) begin
                    state_next  = SETTLE;
                    settle_load = 1'b1;
                end
            end
            SETTLE: begin
                if (ioctl_download) begin
                    state_next = LOAD;
                    start      = 1'b1;
                end else if (settle_cnt <= CNT_W'(1)) begin
                    state_next = IDLE;
                    settle_end = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The config index wins over the region decode when the two overlap.
    always_comb begin
        region_onehot = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            region_onehot[i] = (ioctl_index == 8'(i));
        end
        is_cfg  = (ioctl_index == CFG_INDEX);
        cfg_hit = is_cfg && ({7'b0, ioctl_addr} < 32'(CFG_BYTES));
        mem_hit = !is_cfg && ({24'b0, ioctl_index} < 32'(NUM_REGIONS))
                  && ({1'b0, ioctl_addr} < ADDR_LIMIT);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dn_wr      <= '0;
            dn_addr    <= '0;
            dn_data    <= '0;
            cfg        <= '0;
            checksum   <= '0;
            byte_count <= '0;
            err        <= 1'b0;
            done       <= 1'b0;
            core_reset <= 1'b1;
            settle_cnt <= '0;
        end else begin
            dn_wr      <= '0;
            done       <= settle_end;
            core_reset <= (state_next != IDLE);

            if (settle_load) begin
                settle_cnt <= SETTLE_LOAD;
            end else if (state == SETTLE && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - CNT_W'(1);
            end

            if (start) begin
                checksum   <= '0;
                byte_count <= '0;
                err        <= 1'b0;
            end else if (accept) begin
                checksum   <= checksum + ioctl_dout;
                byte_count <= byte_count + 25'd1;
                if (mem_hit) begin
                    dn_wr   <= region_onehot;
                    dn_addr <= ioctl_addr[ADDR_W-1:0];
                    dn_data <= ioctl_dout;
                end else if (!cfg_hit) begin
                    err <= 1'b1;
                end
                for (int k = 0; k < CFG_BYTES; k++) begin
                    if (cfg_hit && ioctl_addr == 25'(k)) begin
                        cfg[8*k +: 8] <= ioctl_dout;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ioctl_loader.sv
// Self-checking bench for ioctl_loader: vector table, hand-written settle and
// reset sequences, and randomized downloads checked against a byte-level model.
module tb_ioctl_loader;

    localparam int         ADDR_W        = 16;
    localparam int         NUM_REGIONS   = 4;
    localparam logic [7:0] CFG_INDEX     = 8'd1;
    localparam int         CFG_BYTES     = 4;
    localparam int         SETTLE_CYCLES = 16;

    logic                    clk_sys = 1'b0;
    logic                    reset;
    logic                    ioctl_download;
    logic [7:0]              ioctl_index;
    logic                    ioctl_wr;
    logic [24:0]             ioctl_addr;
    logic [7:0]              ioctl_dout;
    logic [ADDR_W-1:0]       dn_addr;
    logic [7:0]              dn_data;
    logic [NUM_REGIONS-1:0]  dn_wr;
    logic [CFG_BYTES*8-1:0]  cfg;
    logic                    core_reset;
    logic                    done;
    logic [7:0]              checksum;
    logic [24:0]             byte_count;
    logic                    err;

    ioctl_loader #(
        .ADDR_W(ADDR_W), .NUM_REGIONS(NUM_REGIONS), .CFG_INDEX(CFG_INDEX),
        .CFG_BYTES(CFG_BYTES), .SETTLE_CYCLES(SETTLE_CYCLES)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .dn_addr(dn_addr), .dn_data(dn_data),
        .dn_wr(dn_wr), .cfg(cfg), .core_reset(core_reset), .done(done),
        .checksum(checksum), .byte_count(byte_count), .err(err)
    );

    always #5 clk_sys = ~clk_sys;

    int assert_count = 0;
    int fail_count   = 0;

    // Pulse counters sampled 2 time units after each rising edge.
    int mon_pulses = 0;
    int mon_done   = 0;
    always @(posedge clk_sys) begin
        #2;
        if (dn_wr != '0) mon_pulses++;
        if (done) mon_done++;
    end

    // Reference model: download-level totals and the config byte image.
    int         m_sum;
    int         m_count;
    bit         m_err;
    int         m_pulses = 0;
    int         m_done   = 0;
    logic [7:0] m_cfg [CFG_BYTES];

    typedef struct {
        bit          first;
        logic [7:0]  idx;
        logic [24:0] addr;
        logic [7:0]  data;
        logic [3:0]  exp_wr;
        logic [7:0]  exp_cs;
        logic [24:0] exp_cnt;
        bit          exp_err;
        logic [31:0] exp_cfg;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        assert_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_cfg_word();
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < CFG_BYTES; k++) w[8*k +: 8] = m_cfg[k];
        return w;
    endfunction

    task automatic model_start();
        m_sum   = 0;
        m_count = 0;
        m_err   = 1'b0;
    endtask

    task automatic model_reset();
        model_start();
        for (int k = 0; k < CFG_BYTES; k++) m_cfg[k] = 8'h00;
    endtask

    task automatic check_status(input string tag);
        check_output({tag, "/checksum"}, 32'(checksum), 32'(m_sum));
        check_output({tag, "/byte_count"}, 32'(byte_count), 32'(m_count));
        check_output({tag, "/err"}, 32'(err), 32'(m_err));
        check_output({tag, "/cfg"}, cfg, model_cfg_word());
        check_output({tag, "/dn_wr_pulses"}, 32'(mon_pulses), 32'(m_pulses));
        check_output({tag, "/done_pulses"}, 32'(mon_done), 32'(m_done));
    endtask

    // Called at a falling edge with the DUT in LOAD; returns one falling edge later.
    task automatic apply_stimulus(input logic [7:0] idx, input logic [24:0] addr,
                                  input logic [7:0] data, input bit last);
        bit                     mem_ok;
        bit                     cfg_ok;
        logic [NUM_REGIONS-1:0] exp_wr;
        ioctl_index = idx;
        ioctl_addr  = addr;
        ioctl_dout  = data;
        ioctl_wr    = 1'b1;
        if (last) ioctl_download = 1'b0;
        cfg_ok = (idx == CFG_INDEX) && (addr < CFG_BYTES);
        mem_ok = (idx != CFG_INDEX) && (idx < NUM_REGIONS) && (addr < (1 << ADDR_W));
        m_sum   = (m_sum + data) % 256;
        m_count = m_count + 1;
        exp_wr  = mem_ok ? (NUM_REGIONS'(1) << idx) : '0;
        if (mem_ok) m_pulses++;
        else if (cfg_ok) m_cfg[addr] = data;
        else m_err = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        check_output("dn_wr", 32'(dn_wr), 32'(exp_wr));
        if (mem_ok) begin
            check_output("dn_addr", 32'(dn_addr), 32'(addr[ADDR_W-1:0]));
            check_output("dn_data", 32'(dn_data), 32'(data));
        end
    endtask

    task automatic start_download();
        if (ioctl_download) begin
            ioctl_download = 1'b0;
            @(negedge clk_sys);
        end
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        model_start();
    endtask

    task automatic finish_download(input string tag);
        int n;
        ioctl_download = 1'b0;
        n = 0;
        while (n < 4 * SETTLE_CYCLES) begin
            @(posedge clk_sys);
            #1;
            n++;
            if (!core_reset) break;
        end
        check_output({tag, "/settle_timeout"}, 32'(core_reset), 32'd0);
        check_output({tag, "/done_at_release"}, 32'(done), 32'd1);
        m_done++;
        @(negedge clk_sys);
    endtask

    initial begin
        int n;
        int cr_low;
        int nbytes;
        int pick;
        logic [7:0]  ridx;
        logic [24:0] raddr;

        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'h00;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = 8'h00;
        model_reset();

        vecs[0]  = '{1'b1, 8'd0,   25'h0,     8'h11, 4'b0001, 8'h11, 25'd1, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 8'd0,   25'h1,     8'h22, 4'b0001, 8'h33, 25'd2, 1'b0, 32'h0000_0000};
        vecs[2]  = '{1'b0, 8'd0,   25'h2,     8'h33, 4'b0001, 8'h66, 25'd3, 1'b0, 32'h0000_0000};
        vecs[3]  = '{1'b1, 8'd1,   25'h0,     8'hA5, 4'b0000, 8'hA5, 25'd1, 1'b0, 32'h0000_00A5};
        vecs[4]  = '{1'b0, 8'd1,   25'h3,     8'h5A, 4'b0000, 8'hFF, 25'd2, 1'b0, 32'h5A00_00A5};
        vecs[5]  = '{1'b0, 8'd1,   25'h4,     8'h01, 4'b0000, 8'h00, 25'd3, 1'b1, 32'h5A00_00A5};
        vecs[6]  = '{1'b1, 8'd2,   25'h10000, 8'h77, 4'b0000, 8'h77, 25'd1, 1'b1, 32'h5A00_00A5};
        vecs[7]  = '{1'b0, 8'd2,   25'hFFFF,  8'h80, 4'b0100, 8'hF7, 25'd2, 1'b1, 32'h5A00_00A5};
        vecs[8]  = '{1'b1, 8'd3,   25'h1234,  8'hF0, 4'b1000, 8'hF0, 25'd1, 1'b0, 32'h5A00_00A5};
        vecs[9]  = '{1'b1, 8'd5,   25'h0,     8'h10, 4'b0000, 8'h10, 25'd1, 1'b1, 32'h5A00_00A5};
        vecs[10] = '{1'b0, 8'hFF,  25'h2,     8'hC3, 4'b0000, 8'hD3, 25'd2, 1'b1, 32'h5A00_00A5};

        // Reset values while reset is held, then release.
        #1;
        check_output("rst/core_reset", 32'(core_reset), 32'd1);
        check_output("rst/dn_wr", 32'(dn_wr), 32'd0);
        check_output("rst/done", 32'(done), 32'd0);
        check_status("rst");
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset = 1'b0;
        @(posedge clk_sys);
        #1;
        check_output("release/core_reset", 32'(core_reset), 32'd0);
        @(negedge clk_sys);

        $display("[TB] table vectors");
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].first) start_download();
            apply_stimulus(vecs[i].idx, vecs[i].addr, vecs[i].data, 1'b0);
            check_output($sformatf("vec%0d/dn_wr", i), 32'(dn_wr), 32'(vecs[i].exp_wr));
            check_output($sformatf("vec%0d/checksum", i), 32'(checksum), 32'(vecs[i].exp_cs));
            check_output($sformatf("vec%0d/byte_count", i), 32'(byte_count), 32'(vecs[i].exp_cnt));
            check_output($sformatf("vec%0d/err", i), 32'(err), 32'(vecs[i].exp_err));
            check_output($sformatf("vec%0d/cfg", i), cfg, vecs[i].exp_cfg);
            check_output($sformatf("vec%0d/core_reset", i), 32'(core_reset), 32'd1);
        end
        finish_download("table");
        check_status("table");

        $display("[TB] settle length and done pulse");
        start_download();
        apply_stimulus(8'd0, 25'h7, 8'h42, 1'b0);
        ioctl_download = 1'b0;
        n = 0;
        while (n < 4 * SETTLE_CYCLES) begin
            @(posedge clk_sys);
            #1;
            n++;
            if (!core_reset) break;
        end
        check_output("settle/edges_to_release", 32'(n), 32'(SETTLE_CYCLES));
        check_output("settle/done_coincident", 32'(done), 32'd1);
        m_done++;
        @(posedge clk_sys);
        #1;
        check_output("settle/done_width", 32'(done), 32'd0);
        @(negedge clk_sys);
        check_status("settle");

        $display("[TB] strobe in idle");
        ioctl_index = 8'd0; ioctl_addr = 25'h1; ioctl_dout = 8'h99; ioctl_wr = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        check_status("idle_strobe");

        $display("[TB] download re-raised during settle");
        start_download();
        apply_stimulus(8'd2, 25'h10000, 8'h3C, 1'b0);
        ioctl_download = 1'b0;
        cr_low = 0;
        for (int k = 0; k < 11; k++) begin
            if (k == 3) begin
                ioctl_index = 8'd0; ioctl_addr = 25'h0; ioctl_dout = 8'h55; ioctl_wr = 1'b1;
            end else begin
                ioctl_wr = 1'b0;
            end
            @(negedge clk_sys);
            if (!core_reset) cr_low++;
        end
        check_status("settle_strobe");
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        model_start();
        if (!core_reset) cr_low++;
        check_output("reraise/core_reset_low_cycles", 32'(cr_low), 32'd0);
        check_status("reraise");
        finish_download("reraise");
        check_status("reraise_end");

        $display("[TB] last byte with download drop");
        start_download();
        apply_stimulus(8'd3, 25'h5, 8'hAB, 1'b1);
        check_output("lastbyte/byte_count", 32'(byte_count), 32'd1);
        check_output("lastbyte/checksum", 32'(checksum), 32'hAB);
        finish_download("lastbyte");
        check_status("lastbyte");

        $display("[TB] randomized downloads");
        for (int d = 0; d < 8; d++) begin
            pick = int'($urandom_range(0, 6));
            ridx = (pick == 6) ? 8'($urandom_range(4, 255)) : 8'(pick);
            nbytes = int'($urandom_range(3, 12));
            start_download();
            for (int b = 0; b < nbytes; b++) begin
                if (ridx == CFG_INDEX) begin
                    raddr = 25'($urandom_range(0, 5));
                end else if ($urandom_range(0, 9) == 0) begin
                    raddr = 25'($urandom_range(32'h1FF_FFFF, 32'h1_0000));
                end else begin
                    raddr = 25'($urandom_range(0, 16'hFFFF));
                end
                apply_stimulus(ridx, raddr, 8'($urandom_range(0, 255)),
                               (b == nbytes - 1) && ($urandom_range(0, 1) == 1));
                if (ioctl_download) repeat (int'($urandom_range(0, 2))) @(negedge clk_sys);
            end
            finish_download($sformatf("rand%0d", d));
            check_status($sformatf("rand%0d", d));
        end

        $display("[TB] asynchronous reset mid-load");
        start_download();
        apply_stimulus(8'd1, 25'h2, 8'hC3, 1'b0);
        ioctl_index = 8'd0; ioctl_addr = 25'h9; ioctl_dout = 8'h5E; ioctl_wr = 1'b1;
        m_pulses++;
        @(posedge clk_sys);
        #3;
        ioctl_wr = 1'b0;
        check_output("prereset/dn_wr", 32'(dn_wr), 32'd1);
        reset = 1'b1;
        #1;
        model_reset();
        check_output("areset/dn_wr", 32'(dn_wr), 32'd0);
        check_output("areset/dn_addr", 32'(dn_addr), 32'd0);
        check_output("areset/dn_data", 32'(dn_data), 32'd0);
        check_output("areset/core_reset", 32'(core_reset), 32'd1);
        check_output("areset/done", 32'(done), 32'd0);
        check_output("areset/checksum", 32'(checksum), 32'd0);
        check_output("areset/byte_count", 32'(byte_count), 32'd0);
        check_output("areset/err", 32'(err), 32'd0);
        check_output("areset/cfg", cfg, 32'd0);
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        model_start();
        check_output("rearm/core_reset", 32'(core_reset), 32'd1);
        apply_stimulus(8'd0, 25'h3, 8'h21, 1'b0);
        check_status("rearm");
        finish_download("rearm");
        check_status("rearm_end");

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/ioctl_loader.md
IOCTL_LOADER -- requirements
Module: ioctl_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning the target-memory address width.
REQ-002 SHALL have parameter NUM_REGIONS, default 4, meaning the number of ROM/RAM regions, selected by ioctl_index 0..NUM_REGIONS-1.
REQ-003 SHALL have parameter CFG_INDEX, default 8'd1, meaning the ioctl_index whose bytes go to the config register instead of memory.
REQ-004 SHALL have parameter CFG_BYTES, default 4, meaning the config register size in bytes.
REQ-005 SHALL have parameter SETTLE_CYCLES, default 16, meaning the hold of core_reset after a download ends.
REQ-006 SHALL have port clk_sys, input, 1 bit: the single clock.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port ioctl_download, input, 1 bit: high for the duration of a transfer.
REQ-009 SHALL have port ioctl_index, input, 8 bits: the target selector.
REQ-010 SHALL have ports ioctl_wr (input, 1 bit), ioctl_addr (input, 25 bits) and ioctl_dout (input, 8 bits): the byte strobe, byte address and byte data.
REQ-011 SHALL have ports dn_addr (output, ADDR_W bits) and dn_data (output, 8 bits): the registered memory write address and data.
REQ-012 SHALL have port dn_wr, output, NUM_REGIONS bits: one-hot write strobe.
REQ-013 SHALL have port cfg, output, CFG_BYTES*8 bits: the config register, byte k at bits [8k+7:8k].
REQ-014 SHALL have port core_reset, output, 1 bit: holds the emulated core in reset.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse when settle completes.
REQ-016 SHALL have ports checksum (output, 8 bits) and byte_count (output, 25 bits): the sum and count of accepted bytes of the last or current download.
REQ-017 SHALL have port err, output, 1 bit: sticky flag for an address or index out of range.

Function
REQ-018 SHALL implement a state machine with states IDLE, LOAD and SETTLE.
REQ-019 SHALL go IDLE->LOAD on ioctl_download=1, and on that entry clear checksum, byte_count and err.
REQ-020 SHALL go LOAD->SETTLE on ioctl_download=0 and load the settle counter with SETTLE_CYCLES-1.
REQ-021 SHALL decrement the counter in SETTLE; at zero it SHALL go to IDLE and pulse done for exactly 1 cycle.
REQ-022 SHALL return SETTLE->LOAD without pulsing done if ioctl_download rises during SETTLE, with counters cleared as in REQ-019.
REQ-023 SHALL drive core_reset=1 in LOAD and SETTLE, and 0 in IDLE.
REQ-024 SHALL accept a byte in LOAD on each ioctl_wr=1 cycle; one strobe is one byte, with no back-pressure.
REQ-025 SHALL, for an accepted byte with index<NUM_REGIONS and ioctl_addr<2^ADDR_W, drive dn_wr[index]=1, dn_addr=ioctl_addr[ADDR_W-1:0] and dn_data=ioctl_dout exactly 1 cycle later, for 1 cycle.
REQ-026 SHALL keep dn_wr all-zero in every other cycle.
REQ-027 SHALL, for index==CFG_INDEX and ioctl_addr<CFG_BYTES, write cfg byte ioctl_addr with ioctl_dout 1 cycle later; no dn_wr SHALL be asserted for it.
REQ-028 SHALL, for any other accepted byte (address out of range, CFG address >= CFG_BYTES, or unknown index), drop the write and set err=1.
REQ-029 SHALL increment byte_count by 1 for every accepted byte, including dropped ones.
REQ-030 SHALL add ioctl_dout to checksum modulo 256 for every accepted byte, including dropped ones.
REQ-031 SHALL ignore ioctl_wr while in IDLE or SETTLE: no strobe, no count, no error.
REQ-032 SHALL retain cfg across downloads to other indices; only CFG_INDEX writes change it.
REQ-033 SHALL, when the LOAD->SETTLE transition and a final ioctl_wr occur in the same cycle, accept that byte.

Reset
REQ-034 SHALL, on reset=1 and asynchronously, set state=IDLE, dn_wr=0, dn_addr=0, dn_data=0, cfg=0, checksum=0, byte_count=0, err=0, done=0 and core_reset=1.
REQ-035 SHALL go to IDLE after reset release with core_reset=0 from the first clock edge.
REQ-036 SHALL abort a download when reset asserts mid-download; the transfer SHALL NOT resume if ioctl_download is still high at release, but SHALL re-enter LOAD per REQ-019.

Verification
REQ-037 SHALL cover this scenario: index 0, bytes 0x11,0x22,0x33 at addr 0..2 -> dn_wr=4'b0001 pulses 1 cycle after each; checksum=0x66; byte_count=3; err=0.
REQ-038 SHALL cover this scenario: index 1, bytes 0xA5 at addr 0 and 0x5A at addr 3 -> cfg=32'h5A0000A5; dn_wr never asserted.
REQ-039 SHALL cover this scenario: index 2, addr 0x10000 with ADDR_W=16 -> no dn_wr; err=1; byte_count=1.
REQ-040 SHALL cover this scenario: download drops, then rises again at settle count 5 -> no done pulse; core_reset stays 1; err and checksum cleared.
REQ-041 SHALL cover this scenario: download of 1 byte ends -> core_reset falls exactly SETTLE_CYCLES cycles after ioctl_download falls, coincident with the done pulse.
REQ-042 SHALL cover this scenario: reset asserted mid-LOAD -> all outputs take their REQ-034 values immediately, without waiting for a clock edge.
